// File: rtl/eu_dispatch_arbiter.sv
// rtl/eu_dispatch_arbiter.sv - credit-based round-robin dispatch of one decoded stream into NUM_EU queues
// Optional: define EU_DISPATCH_STATS_EN to add stall_cnt_o and grant_cnt_o.
package pkg_dtypes;
  typedef struct packed {
    logic [7:0] opcode;
    logic [5:0] dst_tag;
    logic [5:0] src1_tag;
    logic [5:0] src2_tag;
    logic [5:0] rob_id;
  } type_iqueue_entry;
endpackage

module eu_dispatch_arbiter #(
  parameter int NUM_EU            = 4,
  parameter int LOG2_QUEUE_LENGTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  pkg_dtypes::type_iqueue_entry instr_i,
  input  logic                         instr_valid_i,
  input  logic [NUM_EU-1:0]            instr_eu_mask_i,
  output logic                         instr_ready_o,
  output pkg_dtypes::type_iqueue_entry eu_instr_o,
  output logic [NUM_EU-1:0]            eu_instr_valid_o,
  input  logic [NUM_EU-1:0]            eu_pop_i,
`ifdef EU_DISPATCH_STATS_EN
  output logic [31:0]                  stall_cnt_o,
  output logic [NUM_EU*16-1:0]         grant_cnt_o,
`endif
  output logic                         err_o
);
  localparam int PW  = (NUM_EU > 1) ? $clog2(NUM_EU) : 1;
  localparam int PW1 = PW + 1;
  localparam int CW  = LOG2_QUEUE_LENGTH + 1;
  localparam logic [CW-1:0] CREDIT_MAX = CW'(1) << LOG2_QUEUE_LENGTH;

  logic [NUM_EU-1:0][CW-1:0] credit;
  logic [PW-1:0]             ptr;
  logic [NUM_EU-1:0]         has_credit;
  logic [NUM_EU-1:0]         credit_full;
  logic [NUM_EU-1:0]         cand;
  logic [NUM_EU-1:0]         grant_oh;
  logic [PW-1:0]             grant_idx;
  logic                      accept;
  logic                      pop_err;
  logic                      mask_err;

  always_comb begin
    has_credit  = '0;
    credit_full = '0;
    for (int k = 0; k < NUM_EU; k++) begin
      has_credit[k]  = (credit[k] != '0);
      credit_full[k] = (credit[k] == CREDIT_MAX);
    end
  end

  assign cand          = instr_eu_mask_i & has_credit;
  assign instr_ready_o = !reset && (|cand);
  assign accept        = instr_valid_i && instr_ready_o;

  // Rotating priority scan: first candidate at or above ptr, wrapping at NUM_EU.
  always_comb begin : pick
    logic [PW1-1:0] idx;
    logic           found;
    idx       = '0;
    found     = 1'b0;
    grant_idx = '0;
    for (int i = 0; i < NUM_EU; i++) begin
      idx = {1'b0, ptr} + PW1'(i);
      if (idx >= PW1'(NUM_EU)) idx = idx - PW1'(NUM_EU);
      if (!found && cand[idx[PW-1:0]]) begin
        found     = 1'b1;
        grant_idx = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    if (accept) grant_oh[grant_idx] = 1'b1;
  end

  // A pop against a full counter with no matching grant means the queue popped more than it held.
  assign pop_err  = |(eu_pop_i & ~grant_oh & credit_full);
  assign mask_err = instr_valid_i && (instr_eu_mask_i == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      ptr              <= '0;
      eu_instr_valid_o <= '0;
      eu_instr_o       <= '0;
      err_o            <= 1'b0;
      for (int k = 0; k < NUM_EU; k++) credit[k] <= CREDIT_MAX;
    end else begin
      eu_instr_valid_o <= grant_oh;
      err_o            <= err_o | pop_err | mask_err;
      if (accept) begin
        eu_instr_o <= instr_i;
        ptr        <= (grant_idx == PW'(NUM_EU - 1)) ? '0 : grant_idx + PW'(1);
      end
      for (int k = 0; k < NUM_EU; k++) begin
        case ({grant_oh[k], eu_pop_i[k]})
          2'b10:   credit[k] <= credit[k] - CW'(1);
          2'b01:   if (!credit_full[k]) credit[k] <= credit[k] + CW'(1);
          default: ;
        endcase
      end
    end
  end

`ifdef EU_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_o <= '0;
      grant_cnt_o <= '0;
    end else begin
      if (instr_valid_i && !instr_ready_o && (stall_cnt_o != 32'hFFFF_FFFF))
        stall_cnt_o <= stall_cnt_o + 32'd1;
      for (int k = 0; k < NUM_EU; k++)
        if (grant_oh[k]) grant_cnt_o[k*16 +: 16] <= grant_cnt_o[k*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_eu_dispatch_arbiter.sv
// tb/tb_eu_dispatch_arbiter.sv - directed vector bench for eu_dispatch_arbiter
module tb_eu_dispatch_arbiter;
  import pkg_dtypes::*;

  localparam int NUM_EU = 4;

  logic              clk = 1'b0;
  logic              reset;
  type_iqueue_entry  instr_i;
  logic              instr_valid_i;
  logic [NUM_EU-1:0] instr_eu_mask_i;
  logic              instr_ready_o;
  type_iqueue_entry  eu_instr_o;
  logic [NUM_EU-1:0] eu_instr_valid_o;
  logic [NUM_EU-1:0] eu_pop_i;
  logic              err_o;
`ifdef EU_DISPATCH_STATS_EN
  logic [31:0]        stall_cnt_o;
  logic [NUM_EU*16-1:0] grant_cnt_o;
`endif

  eu_dispatch_arbiter #(.NUM_EU(NUM_EU), .LOG2_QUEUE_LENGTH(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .instr_i          (instr_i),
    .instr_valid_i    (instr_valid_i),
    .instr_eu_mask_i  (instr_eu_mask_i),
    .instr_ready_o    (instr_ready_o),
    .eu_instr_o       (eu_instr_o),
    .eu_instr_valid_o (eu_instr_valid_o),
    .eu_pop_i         (eu_pop_i),
`ifdef EU_DISPATCH_STATS_EN
    .stall_cnt_o      (stall_cnt_o),
    .grant_cnt_o      (grant_cnt_o),
`endif
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_fail = 0;

  typedef struct {
    logic       v;
    logic [3:0] m;
    logic [3:0] p;
    logic       rdy;
    logic [3:0] strobe;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] m, input logic [3:0] p, input logic [31:0] d);
    @(posedge clk);
    #1;
    instr_valid_i   = v;
    instr_eu_mask_i = m;
    eu_pop_i        = p;
    instr_i         = type_iqueue_entry'(d);
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset           = 1'b1;
    instr_valid_i   = 1'b0;
    instr_eu_mask_i = '0;
    eu_pop_i        = '0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] exp_data;
    logic [31:0] prev_d;
    logic        prev_acc;

    reset           = 1'b1;
    instr_valid_i   = 1'b1;
    instr_eu_mask_i = 4'hF;
    eu_pop_i        = '0;
    instr_i         = '0;
    @(posedge clk);
    @(negedge clk);
    check("reset_ready", instr_ready_o, 1'b0);
    check("reset_strobe", eu_instr_valid_o, 4'h0);
    check("reset_data", eu_instr_o, 32'h0);
    check("reset_err", err_o, 1'b0);
    do_reset();

    // RR fairness over all four, idle hold, then steering with mask 1010
    tbl[0]  = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h0};
    tbl[1]  = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h1};
    tbl[2]  = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h2};
    tbl[3]  = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h4};
    tbl[4]  = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h8};
    tbl[5]  = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h1};
    tbl[6]  = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h2};
    tbl[7]  = '{1'b1, 4'hF, 4'h0, 1'b1, 4'h4};
    tbl[8]  = '{1'b0, 4'hF, 4'h0, 1'b1, 4'h8};
    tbl[9]  = '{1'b0, 4'hF, 4'h0, 1'b1, 4'h0};
    tbl[10] = '{1'b1, 4'hA, 4'h0, 1'b1, 4'h0};
    tbl[11] = '{1'b1, 4'hA, 4'h0, 1'b1, 4'h2};
    tbl[12] = '{1'b1, 4'hA, 4'h0, 1'b1, 4'h8};
    tbl[13] = '{1'b0, 4'hA, 4'h1, 1'b1, 4'h2};
    tbl[14] = '{1'b0, 4'h0, 4'h0, 1'b0, 4'h0};

    exp_data = '0;
    prev_d   = '0;
    prev_acc = 1'b0;
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].v, tbl[i].m, tbl[i].p, 32'hC0DE_0000 + i);
      if (prev_acc) exp_data = prev_d;
      check("tbl_ready", instr_ready_o, tbl[i].rdy);
      check("tbl_strobe", eu_instr_valid_o, tbl[i].strobe);
      check("tbl_data", eu_instr_o, exp_data);
      check("tbl_err", err_o, 1'b0);
      prev_acc = tbl[i].v && tbl[i].rdy;
      prev_d   = 32'hC0DE_0000 + i;
    end

    // Credit exhaustion on queue 2, then recovery by one pop
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, 4'h4, 4'h0, 32'hE000_0000 + i);
      check("exh_ready", instr_ready_o, (i < 16));
      check("exh_strobe", eu_instr_valid_o, (i >= 1) ? 4'h4 : 4'h0);
    end
    check("exh_credit0", dut.credit[2], 5'd0);
    drive(1'b1, 4'h4, 4'h4, 32'hE000_0010);
    check("exh_pop_ready", instr_ready_o, 1'b0);
    check("exh_pop_strobe", eu_instr_valid_o, 4'h0);
    drive(1'b1, 4'h4, 4'h0, 32'hE000_0010);
    check("exh_after_ready", instr_ready_o, 1'b1);
    check("exh_after_strobe", eu_instr_valid_o, 4'h0);
    drive(1'b0, 4'h4, 4'h0, 32'h0);
    check("exh_push_strobe", eu_instr_valid_o, 4'h4);
    check("exh_push_data", eu_instr_o, 32'hE000_0010);
    check("exh_credit_end", dut.credit[2], 5'd0);

    // Grant and pop on the same queue in the same cycle
    do_reset();
    for (int i = 0; i < 11; i++) drive(1'b1, 4'h2, 4'h0, 32'hB000_0000 + i);
    drive(1'b1, 4'h2, 4'h2, 32'hB000_0100);
    check("gp_credit_pre", dut.credit[1], 5'd5);
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    check("gp_credit_post", dut.credit[1], 5'd5);
    check("gp_strobe", eu_instr_valid_o, 4'h2);
    check("gp_err", err_o, 1'b0);

    // Pop overflow at full credit
    do_reset();
    drive(1'b0, 4'h0, 4'h1, 32'h0);
    check("ovf_err_pre", err_o, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    check("ovf_err", err_o, 1'b1);
    check("ovf_credit", dut.credit[0], 5'd16);
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    check("ovf_err_sticky", err_o, 1'b1);
    do_reset();
    check("ovf_err_cleared", err_o, 1'b0);

    // Valid with an empty eligibility mask
    drive(1'b1, 4'h0, 4'h0, 32'hDEAD_0000);
    check("mask0_ready", instr_ready_o, 1'b0);
    drive(1'b0, 4'h0, 4'h0, 32'h0);
    check("mask0_err", err_o, 1'b1);
    check("mask0_strobe", eu_instr_valid_o, 4'h0);
    do_reset();
    check("mask0_err_cleared", err_o, 1'b0);

    // Reset asserted the cycle after an accept
    drive(1'b1, 4'hF, 4'h0, 32'hD000_0001);
    check("rst_pre_ready", instr_ready_o, 1'b1);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("rst_inflight_strobe", eu_instr_valid_o, 4'h1);
    check("rst_ready", instr_ready_o, 1'b0);
    @(posedge clk);
    @(negedge clk);
    check("rst_drop_strobe", eu_instr_valid_o, 4'h0);
    check("rst_data", eu_instr_o, 32'h0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NUM_EU; k++) check("rst_credit", dut.credit[k], 5'd16);
    check("rst_ptr", dut.ptr, 2'd0);
    check("rst_post_ready", instr_ready_o, 1'b1);
`ifdef EU_DISPATCH_STATS_EN
    check("rst_stall_cnt", stall_cnt_o, 32'd0);
`endif
    drive(1'b0, 4'hF, 4'h0, 32'h0);
    check("rst_first_grant", eu_instr_valid_o, 4'h1);
    check("rst_first_data", eu_instr_o, 32'hD000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/eu_dispatch_arbiter.md
Name: eu_dispatch_arbiter

Overview:
- Routes one decoded-instruction stream into NUM_EU execution-unit instruction queues.
- Picks one target queue per instruction: round-robin among the queues the instruction is eligible for and that have free space.
- Tracks free space with per-queue credit counters, not the queues' registered full flags, so there is no push-into-full race.
- Sits between decode/rename and the per-EU instruction queues; one registered output stage.

Parameters:
- NUM_EU, 4, number of execution units/queues (2..8).
- LOG2_QUEUE_LENGTH, 4, log2 of each queue's depth; initial credits = 2**LOG2_QUEUE_LENGTH.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- instr_i  in  $bits(type_iqueue_entry)  instruction from decode (pkg_dtypes::type_iqueue_entry).
- instr_valid_i  in  1  instr_i valid.
- instr_eu_mask_i  in  NUM_EU  eligible-EU mask for instr_i.
- instr_ready_o  out  1  arbiter accepts instr_i this cycle.
- eu_instr_o  out  $bits(type_iqueue_entry)  instruction broadcast to all queues.
- eu_instr_valid_o  out  NUM_EU  one-hot push strobe, one bit per queue.
- eu_pop_i  in  NUM_EU  per-queue pulse: queue handed one entry to its EU.
- err_o  out  1  sticky protocol-error flag.

Behaviour:
- Reset:
  - eu_instr_valid_o=0, eu_instr_o=0, err_o=0.
  - Every credit = 2**LOG2_QUEUE_LENGTH; rr pointer = 0.
  - instr_ready_o=0 while reset is high.
- Candidate set: cand = instr_eu_mask_i & {credit[k]!=0}.
- instr_ready_o = !reset && |cand. It is combinational and does not depend on instr_valid_i.
- Grant:
  - Chosen k = first set bit of cand, scanning from ptr upward with wrap at NUM_EU.
  - Accept = instr_valid_i && instr_ready_o.
- Latency: on accept at cycle T, at T+1 eu_instr_o=instr_i(T) and eu_instr_valid_o=one-hot(k) for exactly one cycle.
- No accept at T: eu_instr_valid_o=0 at T+1; eu_instr_o holds its last value.
- Pointer update:
  - On accept, ptr <= (k+1) mod NUM_EU.
  - Without accept, ptr is unchanged.
- Credits (width LOG2_QUEUE_LENGTH+1), per queue k, each cycle:
  - grant only: credit-1.
  - pop only: credit+1.
  - grant and pop in the same cycle: unchanged.
  - Credits are decremented in the accept cycle, not the push cycle (conservative by one cycle).
- Boundaries:
  - Credit 0: queue excluded from cand. A same-cycle pop does not make it eligible that cycle (the pop is visible next cycle).
  - Pop at full credit with no grant: credit saturates at max; err_o<=1.
  - instr_valid_i with instr_eu_mask_i==0: never accepted; err_o<=1.
  - All eligible queues at 0 credits: instr_ready_o=0; stall until a pop.
  - instr_i and instr_eu_mask_i must stay stable while valid && !ready.
- err_o is cleared only by reset.
- Reset mid-operation:
  - An in-flight output strobe is dropped (valid=0 next cycle).
  - Credits return to full. The queues must be reset at the same time.

Optional Feature:
- Macro: EU_DISPATCH_STATS_EN.
- Defined:
  - Adds output stall_cnt_o[31:0]: counts cycles with instr_valid_i && !instr_ready_o.
  - Saturates at 0xFFFFFFFF; reset to 0.
  - Adds output grant_cnt_o[NUM_EU*16-1:0]: per-queue 16-bit wrapping accept counters, reset to 0.
- Undefined: these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- RR fairness: reset, NUM_EU=4, mask=4'b1111, valid held 8 cycles, no pops -> eu_instr_valid_o sequence 0001,0010,0100,1000,0001,0010,0100,1000, each one cycle after acceptance.
- Credit exhaustion: mask=4'b0100, 17 valid cycles, no pops -> 16 accepts; ready=0 on the 17th; queue-2 credit=0. Pulse eu_pop_i[2] -> ready=1 the cycle after the pop, and the 17th instruction is pushed one cycle after that.
- Simultaneous grant+pop: queue 1 at credit 5, accept to queue 1 with eu_pop_i[1]=1 in the same cycle -> credit stays 5.
- Mask steering: mask=4'b1010, ptr=0 -> grant to 1, ptr=2, next grant to 3, then 1. Queues 0 and 2 are never strobed.
- Errors: eu_pop_i[0] at credit 16 -> err_o=1 next cycle, credit stays 16. Separately, valid with mask=0 -> ready=0, err_o=1. Both clear only after reset.
- Reset mid-stream: assert reset the cycle after an accept -> eu_instr_valid_o=0 next cycle, ready=0 during reset, all credits=16, ptr=0 after release. With EU_DISPATCH_STATS_EN, stall_cnt_o=0 after reset.
